// File: rtl/vga_pattern_generator.sv
// Pixel stage behind the VGA sync/counter controller: renders four registered
// 12-bit test patterns and delays sync/blank by one cycle to stay aligned with RGB.
//
// state        | meaning
// PAT_BARS     | eight vertical colour bars
// PAT_CHECKER  | 32x32 black/white checkerboard
// PAT_GRADIENT | R/G follow column/line, B follows the frame counter
// PAT_BOX      | white box bouncing on a blue background
module vga_pattern_generator #(
  parameter int                      COUNTER_SIZE       = 11,
  parameter logic [COUNTER_SIZE-1:0] H_ACTIVE           = 11'd1024,
  parameter logic [COUNTER_SIZE-1:0] V_ACTIVE           = 11'd768,
  parameter logic [7:0]              FRAMES_PER_PATTERN = 8'd60,
  parameter logic [COUNTER_SIZE-1:0] BOX_SIZE           = 11'd64,
  parameter logic [COUNTER_SIZE-1:0] BOX_STEP           = 11'd4
) (
  input  logic                    control_clock,
  input  logic                    reset,
  input  logic [COUNTER_SIZE-1:0] counter_in_hsync,
  input  logic [COUNTER_SIZE-1:0] counter_in_vsync,
  input  logic                    h_sync_in,
  input  logic                    v_sync_in,
  input  logic                    mode_next,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    h_sync_out,
  output logic                    v_sync_out,
  output logic                    active_out,
  output logic [1:0]              pattern_id
);

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_BOX      = 2'd3
  } pattern_t;

  localparam logic [COUNTER_SIZE-1:0] BAR_W = H_ACTIVE >> 3;
  localparam logic [COUNTER_SIZE-1:0] X_MAX = H_ACTIVE - BOX_SIZE;
  localparam logic [COUNTER_SIZE-1:0] Y_MAX = V_ACTIVE - BOX_SIZE;

  pattern_t                pattern_q, pattern_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic                    pending_q, pending_d;
  logic [COUNTER_SIZE-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic                    dx_q, dx_d, dy_q, dy_d;
  logic                    frame_start, visible, auto_due, advance;
  logic [2:0]              bar_idx;
  logic                    in_box;
  logic [11:0]             rgb_d, rgb_q;
  logic                    h_sync_q, v_sync_q, active_q;

  assign frame_start = (counter_in_hsync == '0) && (counter_in_vsync == '0);
  assign visible     = (counter_in_hsync < H_ACTIVE) && (counter_in_vsync < V_ACTIVE);

  // Returns {dir, pos}; dir=1 moves towards lim. Underflow is checked before subtracting.
  function automatic logic [COUNTER_SIZE:0] step_axis(
    input logic [COUNTER_SIZE-1:0] pos,
    input logic                    dir,
    input logic [COUNTER_SIZE-1:0] lim
  );
    logic [COUNTER_SIZE-1:0] np;
    logic [COUNTER_SIZE:0]   res;
    np = pos + BOX_STEP;
    if (dir) begin
      if (np > lim) res = {1'b0, lim};
      else          res = {1'b1, np};
    end else begin
      if (pos < BOX_STEP) res = {1'b1, {COUNTER_SIZE{1'b0}}};
      else                res = {1'b0, pos - BOX_STEP};
    end
    return res;
  endfunction

  always_comb begin
    pattern_d   = pattern_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q | mode_next;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    auto_due    = 1'b0;
    advance     = 1'b0;
    if (frame_start) begin
      auto_due = (FRAMES_PER_PATTERN != 8'd0) &&
                 (frame_cnt_q == FRAMES_PER_PATTERN - 8'd1);
      // A request landing on the frame_start cycle itself is honoured immediately.
      advance  = pending_q | mode_next | auto_due;
      {dx_d, box_x_d} = step_axis(box_x_q, dx_q, X_MAX);
      {dy_d, box_y_d} = step_axis(box_y_q, dy_q, Y_MAX);
      if (advance) begin
        frame_cnt_d = 8'd0;
        pending_d   = 1'b0;
        case (pattern_q)
          PAT_BARS:     pattern_d = PAT_CHECKER;
          PAT_CHECKER:  pattern_d = PAT_GRADIENT;
          PAT_GRADIENT: pattern_d = PAT_BOX;
          PAT_BOX:      pattern_d = PAT_BARS;
          default:      pattern_d = PAT_BARS;
        endcase
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Rendering uses the next-state values so the frame_start pixel already
  // reflects the new frame's pattern, counter and box position.
  always_comb begin
    rgb_d   = 12'h000;
    bar_idx = 3'(counter_in_hsync / BAR_W);
    in_box  = ({1'b0, counter_in_hsync} >= {1'b0, box_x_d}) &&
              ({1'b0, counter_in_hsync} <  ({1'b0, box_x_d} + {1'b0, BOX_SIZE})) &&
              ({1'b0, counter_in_vsync} >= {1'b0, box_y_d}) &&
              ({1'b0, counter_in_vsync} <  ({1'b0, box_y_d} + {1'b0, BOX_SIZE}));
    if (visible) begin
      case (pattern_d)
        PAT_BARS:     rgb_d = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
        PAT_CHECKER:  rgb_d = {12{counter_in_hsync[5] ^ counter_in_vsync[5]}};
        PAT_GRADIENT: rgb_d = {counter_in_hsync[9:6], counter_in_vsync[9:6], frame_cnt_d[3:0]};
        PAT_BOX:      rgb_d = in_box ? 12'hFFF : 12'h00F;
        default:      rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge control_clock) begin
    if (reset) begin
      pattern_q   <= PAT_BARS;
      frame_cnt_q <= 8'd0;
      pending_q   <= 1'b0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      rgb_q       <= 12'h000;
      h_sync_q    <= 1'b0;
      v_sync_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      rgb_q       <= rgb_d;
      h_sync_q    <= h_sync_in;
      v_sync_q    <= v_sync_in;
      active_q    <= visible;
    end
  end

  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign h_sync_out = h_sync_q;
  assign v_sync_out = v_sync_q;
  assign active_out = active_q;
  assign pattern_id = pattern_q;

endmodule

// File: tb/tb_vga_pattern_generator.sv
// Scoreboard bench for vga_pattern_generator: three instances (default, small
// bouncing-box geometry, fast auto-advance) driven from shared counters.
module tb_vga_pattern_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [10:0] h = '0, v = '0;
  logic        hs = 1'b0, vs = 1'b0;
  logic        mn_a = 1'b0, mn_b = 1'b0, mn_c = 1'b0;

  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic       hso_a, vso_a, act_a, hso_b, vso_b, act_b, hso_c, vso_c, act_c;
  logic [1:0] pid_a, pid_b, pid_c;

  vga_pattern_generator dut_a (
    .control_clock(clk), .reset(rst), .counter_in_hsync(h), .counter_in_vsync(v),
    .h_sync_in(hs), .v_sync_in(vs), .mode_next(mn_a),
    .red(r_a), .green(g_a), .blue(b_a), .h_sync_out(hso_a), .v_sync_out(vso_a),
    .active_out(act_a), .pattern_id(pid_a)
  );

  vga_pattern_generator #(
    .H_ACTIVE(11'd128), .V_ACTIVE(11'd64), .FRAMES_PER_PATTERN(8'd0),
    .BOX_SIZE(11'd16), .BOX_STEP(11'd40)
  ) dut_b (
    .control_clock(clk), .reset(rst), .counter_in_hsync(h), .counter_in_vsync(v),
    .h_sync_in(hs), .v_sync_in(vs), .mode_next(mn_b),
    .red(r_b), .green(g_b), .blue(b_b), .h_sync_out(hso_b), .v_sync_out(vso_b),
    .active_out(act_b), .pattern_id(pid_b)
  );

  vga_pattern_generator #(.FRAMES_PER_PATTERN(8'd3)) dut_c (
    .control_clock(clk), .reset(rst), .counter_in_hsync(h), .counter_in_vsync(v),
    .h_sync_in(hs), .v_sync_in(vs), .mode_next(mn_c),
    .red(r_c), .green(g_c), .blue(b_c), .h_sync_out(hso_c), .v_sync_out(vso_c),
    .active_out(act_c), .pattern_id(pid_c)
  );

  typedef struct {
    int          sel;
    logic [16:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic in_valid = 1'b0;
  logic out_valid = 1'b0;

  always @(posedge clk) out_valid <= in_valid;

  function automatic logic [16:0] obs(input int sel);
    case (sel)
      0:       return {r_a, g_a, b_a, hso_a, vso_a, act_a, pid_a};
      1:       return {r_b, g_b, b_b, hso_b, vso_b, act_b, pid_b};
      default: return {r_c, g_c, b_c, hso_c, vso_c, act_c, pid_c};
    endcase
  endfunction

  exp_t        mon_e;
  logic [16:0] mon_got;

  always @(negedge clk) begin
    if (out_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_empty: DUT output arrived with no expectation queued");
      end else begin
        mon_e   = sb.pop_front();
        mon_got = obs(mon_e.sel);
        if (mon_got === mon_e.exp) n_pass++;
        else $display("FAIL %s (dut %0d): got rgb=%h hs=%b vs=%b act=%b pid=%0d, want rgb=%h hs=%b vs=%b act=%b pid=%0d",
                      mon_e.name, mon_e.sel, mon_got[16:5], mon_got[4], mon_got[3], mon_got[2], mon_got[1:0],
                      mon_e.exp[16:5], mon_e.exp[4], mon_e.exp[3], mon_e.exp[2], mon_e.exp[1:0]);
      end
    end
  end

  task automatic drive(input logic r, input int hh, input int vv, input logic s_h, input logic s_v,
                       input logic ma, input logic mb, input logic mc, input logic chk, input int sel,
                       input logic [11:0] rgb, input logic a, input logic [1:0] pid, input string name);
    exp_t it;
    @(negedge clk);
    rst = r; h = 11'(hh); v = 11'(vv); hs = s_h; vs = s_v;
    mn_a = ma; mn_b = mb; mn_c = mc;
    in_valid = chk;
    if (chk) begin
      it.sel  = sel;
      it.exp  = r ? 17'd0 : {rgb, s_h, s_v, a, pid};
      it.name = name;
      sb.push_back(it);
    end
  endtask

  task automatic px(input int sel, input int hh, input int vv, input logic [11:0] rgb,
                    input logic a, input logic [1:0] pid, input string name);
    drive(1'b0, hh, vv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sel, rgb, a, pid, name);
  endtask

  task automatic idle(input int hh, input int vv);
    drive(1'b0, hh, vv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b0, 2'd0, "idle");
  endtask

  task automatic reset_quiet();
    drive(1'b1, 5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b0, 2'd0, "reset");
  endtask

  logic [11:0] fpp_rgb [12] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000,
                                12'h001, 12'h002, 12'h00F, 12'h00F, 12'h00F, 12'hFFF};
  logic [1:0]  fpp_pid [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
  int          bx [7] = '{112, 72, 32, 0, 40, 80, 112};
  int          by [7] = '{8, 0, 40, 48, 8, 0, 40};
  logic [7:0]  hs_pat = 8'b1011_0010;
  logic [7:0]  vs_pat = 8'b0110_0111;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held three cycles mid-frame, then the first frame.
    idle(300, 200);
    idle(300, 200);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 300, 200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 12'h000, 1'b0, 2'd0, "reset_state");
    px(0, 0, 0, 12'hFFF, 1'b1, 2'd0, "first_pixel");

    px(0, 0,    10,  12'hFFF, 1'b1, 2'd0, "bars_h0");
    px(0, 128,  10,  12'hFF0, 1'b1, 2'd0, "bars_h128");
    px(0, 512,  10,  12'hF0F, 1'b1, 2'd0, "bars_h512");
    px(0, 1023, 10,  12'h000, 1'b1, 2'd0, "bars_h1023");
    px(0, 1024, 10,  12'h000, 1'b0, 2'd0, "bars_h1024");
    px(0, 5,    768, 12'h000, 1'b0, 2'd0, "v_blank");

    // Two requests in one frame give a single step at the next frame_start.
    drive(1'b0, 100, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 12'hFFF, 1'b1, 2'd0, "mn_pulse1");
    drive(1'b0, 200, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 12'hFF0, 1'b1, 2'd0, "mn_pulse2");
    px(0, 300, 30, 12'h0FF, 1'b1, 2'd0, "pending_hold");
    px(0, 0,   0,  12'h000, 1'b1, 2'd1, "checker_fs");
    px(0, 32,  0,  12'hFFF, 1'b1, 2'd1, "checker_32_0");
    px(0, 32,  32, 12'h000, 1'b1, 2'd1, "checker_32_32");
    px(0, 0,   32, 12'hFFF, 1'b1, 2'd1, "checker_0_32");
    px(0, 0,   0,  12'h000, 1'b1, 2'd1, "single_step");

    drive(1'b0, 10, 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 12'h000, 1'b1, 2'd1, "mn_to_gradient");
    px(0, 0,   0,   12'h000, 1'b1, 2'd2, "gradient_fs");
    px(0, 640, 448, 12'hA70, 1'b1, 2'd2, "gradient_mid");
    px(0, 0,   0,   12'h001, 1'b1, 2'd2, "gradient_frame1");
    px(0, 64,  64,  12'h111, 1'b1, 2'd2, "gradient_64_64");

    // dut_a box sits at (24,24) after its sixth frame_start.
    drive(1'b0, 10, 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 12'h001, 1'b1, 2'd2, "mn_to_box");
    px(0, 0,  0,  12'h00F, 1'b1, 2'd3, "box_fs");
    px(0, 24, 24, 12'hFFF, 1'b1, 2'd3, "box_corner");
    px(0, 23, 24, 12'h00F, 1'b1, 2'd3, "box_left_edge");
    px(0, 87, 87, 12'hFFF, 1'b1, 2'd3, "box_far_corner");
    px(0, 88, 24, 12'h00F, 1'b1, 2'd3, "box_right_edge");
    drive(1'b0, 500, 500, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 12'h00F, 1'b1, 2'd3, "mn_to_bars");
    px(0, 0, 0, 12'hFFF, 1'b1, 2'd0, "wrap_to_bars");

    // Sync passthrough across the active/blank boundary.
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1020 + i, 10, hs_pat[i], vs_pat[i], 1'b0, 1'b0, 1'b0, 1'b1, 0,
            12'h000, (1020 + i) < 1024, 2'd0, "sync_align");

    // Auto-advance every three frames, then manual+auto in the same frame.
    reset_quiet();
    for (int k = 0; k < 12; k++)
      px(2, 0, 0, fpp_rgb[k], 1'b1, fpp_pid[k], "auto_advance");
    px(2, 0, 0, 12'hFFF, 1'b1, 2'd0, "auto_fs13");
    px(2, 0, 0, 12'hFFF, 1'b1, 2'd0, "auto_fs14");
    drive(1'b0, 7, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 12'hFFF, 1'b1, 2'd0, "mn_when_due");
    px(2, 0, 0, 12'h000, 1'b1, 2'd1, "simultaneous_advance");
    px(2, 0, 0, 12'h000, 1'b1, 2'd1, "no_double_step");

    // Bouncing box on the small geometry, reached by three manual steps.
    reset_quiet();
    for (int k = 1; k <= 9; k++) begin
      if (k <= 3)
        drive(1'b0, 5, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 12'h000, 1'b0, 2'd0, "mn_b");
      if (k < 3) begin
        idle(0, 0);
      end else begin
        px(1, 0, 0, 12'h00F, 1'b1, 2'd3, "box_b_fs");
        px(1, bx[k-3], by[k-3], 12'hFFF, 1'b1, 2'd3, "box_b_origin");
        px(1, bx[k-3] + 15, by[k-3] + 15, 12'hFFF, 1'b1, 2'd3, "box_b_far");
        if (bx[k-3] > 0) px(1, bx[k-3] - 1, by[k-3], 12'h00F, 1'b1, 2'd3, "box_b_left");
        else             px(1, bx[k-3] + 16, by[k-3], 12'h00F, 1'b1, 2'd3, "box_b_right");
      end
    end

    idle(5, 5);
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_generator.md
Name: vga_pattern_generator

Overview:
- Pixel stage downstream of the VGA sync/counter controller. It consumes the horizontal and vertical counters and the sync signals, and produces registered 12-bit RGB test patterns.
- Sync and blank outputs are delayed so they stay aligned with the RGB output.
- Cycles through four test patterns, one of which is an animated bouncing box. Pattern changes only at frame boundaries, so no tearing occurs.

Parameters:
- H_ACTIVE, 11'd1024: visible pixels per line. Must be a multiple of 8.
- V_ACTIVE, 11'd768: visible lines per frame.
- COUNTER_SIZE, 11: width of the h/v counter inputs.
- FRAMES_PER_PATTERN, 8'd60: frames shown before auto-advance. 0 disables auto-advance.
- BOX_SIZE, 11'd64: edge length of the bouncing box, in pixels.
- BOX_STEP, 11'd4: box displacement per frame on each axis.

Ports:
- control_clock  in  1  pixel clock, shared with the sync controller.
- reset  in  1  synchronous, active-high.
- counter_in_hsync  in  COUNTER_SIZE  current pixel column.
- counter_in_vsync  in  COUNTER_SIZE  current line.
- h_sync_in  in  1  horizontal sync from the controller.
- v_sync_in  in  1  vertical sync from the controller.
- mode_next  in  1  single-cycle request to advance the pattern.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.
- h_sync_out  out  1  h_sync_in delayed 1 cycle.
- v_sync_out  out  1  v_sync_in delayed 1 cycle.
- active_out  out  1  visible-region flag, aligned with RGB.
- pattern_id  out  2  current pattern: 0=BARS, 1=CHECKER, 2=GRADIENT, 3=BOX.

Behaviour:

Reset (synchronous, sampled on the rising edge of control_clock):
- red, green, blue, h_sync_out, v_sync_out, active_out all reset to 0.
- pattern_id=0, frame counter=0, pending request=0.
- box_x=0, box_y=0, dx=+1, dy=+1.
- Reset asserted mid-frame forces this state on the next edge. Normal output resumes the cycle after reset deasserts.

Pipeline and frame start:
- Visible region: counter_in_hsync < H_ACTIVE and counter_in_vsync < V_ACTIVE.
- All outputs are registered with 1-cycle latency from the counter inputs.
- Outside the visible region: RGB=0, active_out=0.
- frame_start is the cycle where both counters equal 0. All state updates below happen only on frame_start.

Pattern state machine (BARS -> CHECKER -> GRADIENT -> BOX -> BARS):
- A mode_next pulse sets pending. Further pulses before the next frame_start are absorbed.
- At frame_start, advance if pending=1, or if FRAMES_PER_PATTERN≠0 and frame counter = FRAMES_PER_PATTERN-1.
- Simultaneous manual and auto conditions advance exactly one step.
- On advance: frame counter clears to 0 and pending clears.
- Otherwise the frame counter increments, wrapping at 255.
- The new pattern_id and the first pixel rendered with it appear together at output cycle 1 of the frame.

Pattern definitions (values as {R,G,B}; F = 4'hF):
- BARS: idx = counter_in_hsync / (H_ACTIVE/8). R=F if !idx[1], G=F if !idx[2], B=F if !idx[0], else 0. Order across the screen: white, yellow, cyan, green, magenta, red, blue, black.
- CHECKER: counter_in_hsync[5]^counter_in_vsync[5] → 1 gives white {F,F,F}, 0 gives black.
- GRADIENT: R=counter_in_hsync[9:6], G=counter_in_vsync[9:6], B=frame counter[3:0].
- BOX: white if box_x ≤ h < box_x+BOX_SIZE and box_y ≤ v < box_y+BOX_SIZE, else blue {0,0,F}.

Box motion:
- Box position updates at every frame_start regardless of pattern.
- x axis: nx = box_x ± BOX_STEP.
  - If dx=+1 and nx > H_ACTIVE-BOX_SIZE: clamp box_x to H_ACTIVE-BOX_SIZE and set dx=-1.
  - If dx=-1 and box_x < BOX_STEP: clamp box_x to 0 and set dx=+1.
- y axis behaves identically with V_ACTIVE, box_y and dy.
- Arithmetic is COUNTER_SIZE wide. The underflow check above is done before subtraction, so no wrap occurs.

Test Plan:
- Reset held 3 cycles mid-frame -> RGB=0, syncs=0, pattern_id=0; first visible pixel after frame_start is {F,F,F}.
- BARS, v=10: h=0 → {F,F,F}; h=128 → {F,F,0}; h=512 → {F,0,F}; h=1023 → {0,0,0}; h=1024 → 0 with active_out=0. Each value appears 1 cycle after its counter input.
- mode_next pulsed twice mid-frame -> pattern_id stays 0 until the next frame_start, then becomes 1 (single step). CHECKER check: h=32, v=0 → white; h=32, v=32 → black.
- FRAMES_PER_PATTERN=3, no mode_next -> pattern_id increments after every 3 frames, wrapping 3→0. mode_next raised in the frame where auto-advance is due -> advances by 1 only.
- BOX, small config (H_ACTIVE=128, BOX_SIZE=16, BOX_STEP=40) -> box_x sequence 0, 40, 80, 112 (clamped, dx=-1), 72, 32, 0 (clamped, dx=+1).
- h_sync_in/v_sync_in toggled on arbitrary cycles -> h_sync_out/v_sync_out reproduce them exactly 1 cycle later, aligned with active_out edges.
